// File: rtl/one_wire_pkg.sv
// Shared encodings, FSM states and microsecond timing constants for the 1-Wire PHY.
// All timing values count us_ticks from the start of the phase or slot.
package one_wire_pkg;

   localparam logic [1:0] OW_OP_RESET = 2'b00;
   localparam logic [1:0] OW_OP_WRITE = 2'b01;
   localparam logic [1:0] OW_OP_READ  = 2'b10;

   localparam int T_RST_LOW      = 480;
   localparam int T_PRES_SAMPLE  = 70;
   localparam int T_RST_REC      = 480;
   localparam int T_W0_LOW       = 60;
   localparam int T_W1_LOW       = 6;
   localparam int T_RD_SAMPLE    = 15;
   localparam int T_SLOT_REL_END = 65;
   localparam int T_SLOT         = 70;

   typedef enum logic [2:0] {
      IDLE,
      RST_LOW,
      RST_WAIT,
      RST_REC,
      SLOT_LOW,
      SLOT_REL,
      SLOT_REC,
      FINISH
   } ow_state_e;

endpackage

// File: rtl/one_wire_master_if.sv
// Request/response channel between the command handler and the 1-Wire PHY.
// The handler owns the master modport; the PHY owns the slave modport.
interface one_wire_master_if;
   logic [1:0] op;
   logic       op_valid;
   logic       op_ready;
   logic [7:0] tx_byte;
   logic       done;
   logic [7:0] rx_byte;
   logic       presence;

   modport master (
      output op, op_valid, tx_byte,
      input  op_ready, done, rx_byte, presence
   );

   modport slave (
      input  op, op_valid, tx_byte,
      output op_ready, done, rx_byte, presence
   );
endinterface

// File: rtl/one_wire_us_tick.sv
// Microsecond strobe generator; restart_i zeroes the prescaler so a new op starts phase-aligned.
module one_wire_us_tick #(
   parameter int CLK_FREQ = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart_i,
   output logic tick_o
);

   localparam int DIV = CLK_FREQ / 1_000_000;
   localparam int W   = $clog2(DIV);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = (cnt_q == W'(DIV - 1));
      cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
      if (restart_i) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/one_wire_master.sv
// Standard-speed 1-Wire PHY: runs one reset/presence, write-byte or read-byte op at a time
// and owns all slot timing on the open-drain bus.
module one_wire_master
   import one_wire_pkg::*;
#(
   parameter int CLK_FREQ = 25_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   one_wire_master_if.slave     bus,
   inout  wire                  onewire_io
);

   ow_state_e  state_q, state_d;
   logic [8:0] usCnt_q, usCnt_d;
   logic [2:0] bitCnt_q, bitCnt_d;
   logic [1:0] opReg_q, opReg_d;
   logic [7:0] txShift_q, txShift_d;
   logic [7:0] rxShift_q, rxShift_d;
   logic [7:0] rxByte_q, rxByte_d;
   logic       presence_q, presence_d;
   logic       pullLow_q, pullLow_d;
   logic [1:0] sync_q;
   logic       usTick;
   logic       accept;
   logic [8:0] lowLast;

   assign onewire_io   = pullLow_q ? 1'b0 : 1'bz;
   assign bus.op_ready = (state_q == IDLE) || (state_q == FINISH);
   assign bus.done     = (state_q == FINISH);
   assign bus.rx_byte  = rxByte_q;
   assign bus.presence = presence_q;
   assign accept       = bus.op_valid && bus.op_ready;

   // Only a write of a 0 bit holds the line for the long low time.
   assign lowLast = (opReg_q == OW_OP_WRITE && !txShift_q[0]) ? 9'(T_W0_LOW - 1)
                                                             : 9'(T_W1_LOW - 1);

   one_wire_us_tick #(.CLK_FREQ(CLK_FREQ)) u_tick (
      .clk       (clk),
      .rst       (rst),
      .restart_i (accept),
      .tick_o    (usTick)
   );

   always_comb begin
      state_d    = state_q;
      usCnt_d    = usCnt_q;
      bitCnt_d   = bitCnt_q;
      opReg_d    = opReg_q;
      txShift_d  = txShift_q;
      rxShift_d  = rxShift_q;
      rxByte_d   = rxByte_q;
      presence_d = presence_q;
      pullLow_d  = pullLow_q;

      case (state_q)
         IDLE, FINISH: begin
            state_d = IDLE;
            if (accept) begin
               opReg_d   = bus.op;
               txShift_d = bus.tx_byte;
               bitCnt_d  = '0;
               usCnt_d   = '0;
               case (bus.op)
                  OW_OP_RESET: begin state_d = RST_LOW;  pullLow_d = 1'b1; end
                  OW_OP_WRITE,
                  OW_OP_READ:  begin state_d = SLOT_LOW; pullLow_d = 1'b1; end
                  default:     state_d = FINISH;
               endcase
            end
         end
         RST_LOW: if (usTick) begin
            usCnt_d = usCnt_q + 1'b1;
            if (usCnt_q == 9'(T_RST_LOW - 1)) begin
               state_d   = RST_WAIT;
               usCnt_d   = '0;
               pullLow_d = 1'b0;
            end
         end
         // The counter keeps running from release so recovery ends 480 us after release.
         RST_WAIT: if (usTick) begin
            usCnt_d = usCnt_q + 1'b1;
            if (usCnt_q == 9'(T_PRES_SAMPLE - 1)) begin
               presence_d = ~sync_q[1];
               state_d    = RST_REC;
            end
         end
         RST_REC: if (usTick) begin
            usCnt_d = usCnt_q + 1'b1;
            if (usCnt_q == 9'(T_RST_REC - 1)) state_d = FINISH;
         end
         SLOT_LOW: if (usTick) begin
            usCnt_d = usCnt_q + 1'b1;
            if (usCnt_q == lowLast) begin
               state_d   = SLOT_REL;
               pullLow_d = 1'b0;
            end
         end
         SLOT_REL: if (usTick) begin
            usCnt_d = usCnt_q + 1'b1;
            if (usCnt_q == 9'(T_RD_SAMPLE - 1) && opReg_q == OW_OP_READ)
               rxShift_d = {sync_q[1], rxShift_q[7:1]};
            if (usCnt_q == 9'(T_SLOT_REL_END - 1)) state_d = SLOT_REC;
         end
         SLOT_REC: if (usTick) begin
            usCnt_d = usCnt_q + 1'b1;
            if (usCnt_q == 9'(T_SLOT - 1)) begin
               usCnt_d   = '0;
               bitCnt_d  = bitCnt_q + 1'b1;
               txShift_d = {1'b0, txShift_q[7:1]};
               if (bitCnt_q == 3'd7) begin
                  state_d = FINISH;
                  if (opReg_q == OW_OP_READ) rxByte_d = rxShift_q;
               end else begin
                  state_d   = SLOT_LOW;
                  pullLow_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         usCnt_q    <= '0;
         bitCnt_q   <= '0;
         opReg_q    <= '0;
         txShift_q  <= '0;
         rxShift_q  <= '0;
         rxByte_q   <= '0;
         presence_q <= 1'b0;
         pullLow_q  <= 1'b0;
         sync_q     <= 2'b11;
      end else begin
         state_q    <= state_d;
         usCnt_q    <= usCnt_d;
         bitCnt_q   <= bitCnt_d;
         opReg_q    <= opReg_d;
         txShift_q  <= txShift_d;
         rxShift_q  <= rxShift_d;
         rxByte_q   <= rxByte_d;
         presence_q <= presence_d;
         pullLow_q  <= pullLow_d;
         sync_q     <= {sync_q[0], onewire_io};
      end
   end

endmodule
